// File: rtl/bitstream_cic_decimator.sv
// bitstream_cic_decimator: 4th-order CIC decimator turning a 1-bit bitstream into
// signed PCM on a valid/ready output. Rev 1.0
`default_nettype none

module bitstream_cic_decimator #(
  parameter int LOG2_R   = 6,
  parameter int OUT_BITS = 24
) (
  input  logic                       CLK_3M,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       data_i,
  output logic signed [OUT_BITS-1:0] data_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic                       overrun_o
);

  localparam int W     = 4 * LOG2_R + 2;
  localparam int SHIFT = W - OUT_BITS - 1;
  localparam logic signed [W-1:0] Y_MAX = {{(W-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
  localparam logic signed [W-1:0] Y_MIN = ~Y_MAX;

  logic signed [W-1:0] x;
  logic signed [W-1:0] i1, i2, i3, i4;
  logic signed [W-1:0] d1, d2, d3, d4;
  logic signed [W-1:0] c1, c2, c3, c4;
  logic signed [W-1:0] scaled;
  logic signed [OUT_BITS-1:0] y;
  logic [LOG2_R-1:0] cnt;
  logic dec_evt;

  // +1 for a one bit, -1 (all ones) for a zero bit
  assign x       = {{(W-1){~data_i}}, 1'b1};
  assign dec_evt = enable && (cnt == {LOG2_R{1'b1}});

  assign c1     = i4 - d1;
  assign c2     = c1 - d2;
  assign c3     = c2 - d3;
  assign c4     = c3 - d4;
  assign scaled = c4 >>> SHIFT;

  always_comb begin
    y = scaled[OUT_BITS-1:0];
    if (scaled > Y_MAX) begin
      y = Y_MAX[OUT_BITS-1:0];
    end else if (scaled < Y_MIN) begin
      y = Y_MIN[OUT_BITS-1:0];
    end
  end

  always_ff @(posedge CLK_3M) begin
    if (reset) begin
      i1  <= '0;
      i2  <= '0;
      i3  <= '0;
      i4  <= '0;
      d1  <= '0;
      d2  <= '0;
      d3  <= '0;
      d4  <= '0;
      cnt <= '0;
    end else if (enable) begin
      // Integrators wrap freely; the combs cancel the wrap modulo 2^W
      i1  <= i1 + x;
      i2  <= i2 + i1;
      i3  <= i3 + i2;
      i4  <= i4 + i3;
      cnt <= cnt + 1'b1;
      if (dec_evt) begin
        d1 <= i4;
        d2 <= c1;
        d3 <= c2;
        d4 <= c3;
      end
    end
  end

  always_ff @(posedge CLK_3M) begin
    if (reset) begin
      data_o    <= '0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= dec_evt && valid_o && !ready_i;
      if (dec_evt) begin
        data_o  <= y;
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
